// File: rtl/pet_clken_gen.sv
// Clock-enable and system-reset generator: video x2/x1p/x1n, CPU enable, sequenced sys_reset; all outputs registered (1 clk).
// PET_CLKEN_TURBO_EN adds the runtime turbo CPU rate; without it the CPU rate is fixed at CPU_NORMAL.
module pet_clken_gen #(
  parameter int VID_SHIFT   = 3,
  parameter int CPU_W       = 7,
  parameter int CPU_NORMAL  = 111,
  parameter int CPU_TURBO   = 20,
  parameter int POR_CYCLES  = 100000000,
  parameter int HOLD_CYCLES = 14
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reset_req,
  input  logic turbo,
  input  logic cpu_stop,
  output logic ce_x2,
  output logic ce_x1p,
  output logic ce_x1n,
  output logic ce_cpu,
  output logic turbo_active,
  output logic sys_reset
);

  localparam int VW = VID_SHIFT + 1;
  localparam logic [VW-1:0]    VDIV_HALF   = {1'b1, {VID_SHIFT{1'b0}}};
  localparam logic [CPU_W-1:0] RATE_NORMAL = CPU_W'(CPU_NORMAL);
  localparam logic [26:0]      POR_INIT    = 27'(POR_CYCLES);
  localparam logic [7:0]       HOLD_MAX    = 8'(HOLD_CYCLES);

  logic [VW-1:0]    vdiv;
  logic [CPU_W-1:0] cpu_div;
  logic [CPU_W-1:0] rate;
  logic             cpu_wrap;
  logic [26:0]      por_cnt;
  logic [7:0]       hold_cnt;

  // Video divider wraps naturally; x1p and x1n sit half a period apart.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vdiv   <= '0;
      ce_x2  <= 1'b0;
      ce_x1p <= 1'b0;
      ce_x1n <= 1'b0;
    end else begin
      vdiv   <= vdiv + 1'b1;
      ce_x2  <= (vdiv[VID_SHIFT-1:0] == '0);
      ce_x1p <= (vdiv == '0);
      ce_x1n <= (vdiv == VDIV_HALF);
    end
  end

  assign cpu_wrap = (cpu_div == rate);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_div <= '0;
      ce_cpu  <= 1'b0;
    end else begin
      cpu_div <= cpu_wrap ? '0 : cpu_div + 1'b1;
      ce_cpu  <= (cpu_div == '0) && !cpu_stop;
    end
  end

`ifdef PET_CLKEN_TURBO_EN
  localparam logic [CPU_W-1:0] RATE_TURBO = CPU_W'(CPU_TURBO);

  // Rate is only reloaded at a period boundary so no period is cut short.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate         <= RATE_NORMAL;
      turbo_active <= 1'b0;
    end else begin
      if (cpu_wrap)
        rate <= turbo ? RATE_TURBO : RATE_NORMAL;
      turbo_active <= (rate == RATE_TURBO);
    end
  end
`else
  localparam int UNUSED_CPU_TURBO = CPU_TURBO;
  logic unused_turbo;

  assign unused_turbo = turbo;
  assign rate         = RATE_NORMAL;
  assign turbo_active = 1'b0;
`endif

  // sys_reset drops only once POR has expired and the request has been quiet for the hold time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      por_cnt   <= POR_INIT;
      hold_cnt  <= '0;
      sys_reset <= 1'b1;
    end else begin
      if (por_cnt != '0)
        por_cnt <= por_cnt - 1'b1;
      if (reset_req) begin
        sys_reset <= 1'b1;
        hold_cnt  <= '0;
      end else begin
        if (sys_reset && hold_cnt != HOLD_MAX)
          hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_MAX && por_cnt == '0)
          sys_reset <= 1'b0;
      end
    end
  end

endmodule
